// File: rtl/mem_xfer_ctrl_pkg.sv
// Shared types and default sizes for the memory transfer controller.
package mem_xfer_ctrl_pkg;

  localparam int DefDw    = 8;
  localparam int DefAw    = 4;
  localparam int DefDepth = 16;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWr     = 3'd1,
    StRdAddr = 3'd2,
    StRdWait = 3'd3,
    StTxReq  = 3'd4,
    StTxWait = 3'd5,
    StDoneWr = 3'd6,
    StDoneRd = 3'd7
  } state_e;

endpackage

// File: rtl/mem_xfer_ctrl_idx.sv
// Word index counter shared by the write and read passes.
// last_o flags the final word so DEPTH == 2**AW never needs an extra bit.
module mem_xfer_ctrl_idx #(
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] idx_o,
  output logic          last_o
);

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  logic [AW-1:0] idx_q;
  logic [AW-1:0] idx_d;

  // Clear has priority over increment so a new pass always starts at word 0.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + AW'(1);
    end
  end

  // Index register, cleared on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == LastIdx);

endmodule

// File: rtl/mem_xfer_ctrl.sv
// Responder for the start/done handshake: fills the RAM with a seeded
// pattern on start_wr_i, or reads it back and streams it to the UART on start_rd_i.
module mem_xfer_ctrl
  import mem_xfer_ctrl_pkg::*;
#(
  parameter int DW    = DefDw,
  parameter int AW    = DefAw,
  parameter int DEPTH = DefDepth
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_wr_i,
  input  logic          start_rd_i,
  input  logic [DW-1:0] seed_i,
  output logic          done_wr_o,
  output logic          done_rd_o,
  output logic          busy_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          tx_start_o,
  output logic [DW-1:0] tx_data_o,
  input  logic          tx_done_i
);

  state_e        state_q;
  state_e        state_d;
  logic [DW-1:0] seed_q;
  logic [DW-1:0] txData_q;
  logic [AW-1:0] idx;
  logic          idxLast;
  logic          idxClr;
  logic          idxInc;
  logic          seedLoad;
  logic          txLoad;

  mem_xfer_ctrl_idx #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_idx (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (idxClr),
    .inc_i  (idxInc),
    .idx_o  (idx),
    .last_o (idxLast)
  );

  // Next-state and control decode; write wins when both starts arrive together.
  always_comb begin
    state_d  = state_q;
    idxClr   = 1'b0;
    idxInc   = 1'b0;
    seedLoad = 1'b0;
    txLoad   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_wr_i) begin
          seedLoad = 1'b1;
          idxClr   = 1'b1;
          state_d  = StWr;
        end else if (start_rd_i) begin
          idxClr  = 1'b1;
          state_d = StRdAddr;
        end
      end
      StWr: begin
        if (idxLast) begin
          state_d = StDoneWr;
        end else begin
          idxInc = 1'b1;
        end
      end
      StRdAddr: state_d = StRdWait;
      StRdWait: begin
        txLoad  = 1'b1;
        state_d = StTxReq;
      end
      StTxReq:  state_d = StTxWait;
      StTxWait: begin
        if (tx_done_i) begin
          if (idxLast) begin
            state_d = StDoneRd;
          end else begin
            idxInc  = 1'b1;
            state_d = StRdAddr;
          end
        end
      end
      StDoneWr: state_d = StIdle;
      StDoneRd: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, seed and transmit byte registers; the byte is held until the next read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      seed_q   <= '0;
      txData_q <= '0;
    end else begin
      state_q <= state_d;
      if (seedLoad) begin
        seed_q <= seed_i;
      end
      if (txLoad) begin
        txData_q <= mem_rdata_i;
      end
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign mem_we_o    = (state_q == StWr);
  assign mem_addr_o  = idx;
  assign mem_wdata_o = (state_q == StWr) ? (seed_q + DW'(idx)) : '0;
  assign tx_start_o  = (state_q == StTxReq);
  assign tx_data_o   = txData_q;
  assign done_wr_o   = (state_q == StDoneWr);
  assign done_rd_o   = (state_q == StDoneRd);

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Bench for mem_xfer_ctrl with a sync RAM model, a UART TX model and a
// transaction-level reference that predicts outputs every cycle.
module tb_mem_xfer_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  localparam int M_IDLE  = 0;
  localparam int M_WRITE = 1;
  localparam int M_WDONE = 2;
  localparam int M_READ  = 3;
  localparam int M_RDONE = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_wr_i;
  logic          start_rd_i;
  logic [DW-1:0] seed_i;
  logic          done_wr_o;
  logic          done_rd_o;
  logic          busy_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          tx_start_o;
  logic [DW-1:0] tx_data_o;
  logic          tx_done_i;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [DEPTH];
  int         uartCnt = 0;
  logic       earlyDone;

  // Reference model state
  int         mMode = M_IDLE;
  int         mK = 0;
  int         mB = 0;
  int         mS = 0;
  logic [7:0] mSeed = 8'h00;
  logic [7:0] refRam [DEPTH];

  // Observed event counters for directed checks
  int         txCount = 0;
  int         doneWrCount = 0;
  int         doneRdCount = 0;
  int         weCount = 0;
  logic [7:0] txBytes [32];

  mem_xfer_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_wr_i  (start_wr_i),
    .start_rd_i  (start_rd_i),
    .seed_i      (seed_i),
    .done_wr_o   (done_wr_o),
    .done_rd_o   (done_rd_o),
    .busy_o      (busy_o),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .tx_start_o  (tx_start_o),
    .tx_data_o   (tx_data_o),
    .tx_done_i   (tx_done_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous RAM: one-cycle read latency, write on enable
  always @(posedge clk_i) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= ram[mem_addr_o];
  end

  // UART TX model: tx_done 10 cycles after tx_start, optional stray tx_done in the request cycle
  always begin
    @(posedge clk_i);
    #1;
    tx_done_i = 1'b0;
    if (!rst_ni) begin
      uartCnt = 0;
    end else begin
      if (uartCnt > 0) begin
        uartCnt--;
        if (uartCnt == 0) tx_done_i = 1'b1;
      end
      if (tx_start_o) begin
        uartCnt = 10;
        if (earlyDone) tx_done_i = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy_o, 0);
    checkOutput({tag, "_done_wr"}, done_wr_o, 0);
    checkOutput({tag, "_done_rd"}, done_rd_o, 0);
    checkOutput({tag, "_we"}, mem_we_o, 0);
    checkOutput({tag, "_addr"}, mem_addr_o, 0);
    checkOutput({tag, "_wdata"}, mem_wdata_o, 0);
    checkOutput({tag, "_tx_start"}, tx_start_o, 0);
    checkOutput({tag, "_tx_data"}, tx_data_o, 0);
  endtask

  // Cycle-by-cycle comparison against the reference model, inputs sampled mid-cycle
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_we", mem_we_o, 0);
      checkOutput("rst_tx_start", tx_start_o, 0);
      checkOutput("rst_done", {30'd0, done_wr_o, done_rd_o}, 0);
      mMode = M_IDLE;
    end else begin
      case (mMode)
        M_IDLE: begin
          checkOutput("idle_busy", busy_o, 0);
          checkOutput("idle_we", mem_we_o, 0);
          checkOutput("idle_tx_start", tx_start_o, 0);
          checkOutput("idle_done", {30'd0, done_wr_o, done_rd_o}, 0);
          if (start_wr_i) begin
            mSeed = seed_i;
            mK    = 0;
            mMode = M_WRITE;
          end else if (start_rd_i) begin
            mB    = 0;
            mS    = 1;
            mMode = M_READ;
          end
        end
        M_WRITE: begin
          refRam[mK] = mSeed + 8'(mK);
          checkOutput("wr_busy", busy_o, 1);
          checkOutput("wr_we", mem_we_o, 1);
          checkOutput("wr_addr", mem_addr_o, mK);
          checkOutput("wr_data", mem_wdata_o, refRam[mK]);
          checkOutput("wr_other", {29'd0, tx_start_o, done_wr_o, done_rd_o}, 0);
          if (mK == DEPTH - 1) mMode = M_WDONE;
          else mK++;
        end
        M_WDONE: begin
          checkOutput("wdone_busy", busy_o, 1);
          checkOutput("wdone_pulse", {28'd0, done_wr_o, done_rd_o, mem_we_o, tx_start_o}, 8);
          mMode = M_IDLE;
        end
        M_READ: begin
          checkOutput("rd_busy", busy_o, 1);
          checkOutput("rd_we", mem_we_o, 0);
          checkOutput("rd_done", {30'd0, done_wr_o, done_rd_o}, 0);
          checkOutput("rd_tx_start", tx_start_o, (mS == 3) ? 1 : 0);
          if (mS == 1) checkOutput("rd_addr", mem_addr_o, mB);
          if (mS >= 3) checkOutput("rd_tx_data", tx_data_o, refRam[mB]);
          if (mS < 4) begin
            mS++;
          end else if (tx_done_i) begin
            if (mB == DEPTH - 1) mMode = M_RDONE;
            else begin
              mB++;
              mS = 1;
            end
          end
        end
        M_RDONE: begin
          checkOutput("rdone_busy", busy_o, 1);
          checkOutput("rdone_pulse", {28'd0, done_wr_o, done_rd_o, mem_we_o, tx_start_o}, 4);
          mMode = M_IDLE;
        end
        default: mMode = M_IDLE;
      endcase
    end
    if (tx_start_o) begin
      if (txCount < 32) txBytes[txCount] = tx_data_o;
      txCount++;
    end
    if (done_wr_o) doneWrCount++;
    if (done_rd_o) doneRdCount++;
    if (mem_we_o) weCount++;
  end

  task automatic clearCounters();
    txCount     = 0;
    doneWrCount = 0;
    doneRdCount = 0;
    weCount     = 0;
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] sd);
    @(posedge clk_i);
    #1;
    start_wr_i = wr;
    start_rd_i = rd;
    seed_i     = sd;
    @(posedge clk_i);
    #1;
    start_wr_i = 1'b0;
    start_rd_i = 1'b0;
  endtask

  function automatic logic doneSel(input int which);
    return (which == 0) ? done_wr_o : done_rd_o;
  endfunction

  task automatic waitDone(input string name, input int which, input int bound, output int cyc);
    cyc = 1;
    while (!doneSel(which) && cyc < bound) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    if (!doneSel(which)) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: timeout after %0d cycles", name, cyc);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    int cyc;
    rst_ni     = 1'b0;
    start_wr_i = 1'b0;
    start_rd_i = 1'b0;
    seed_i     = 8'h00;
    earlyDone  = 1'b0;
    idleCycles(2);
    checkResetOutputs("reset");
    rst_ni = 1'b1;
    idleCycles(2);

    // Test 1: pattern write with seed 8'h30
    clearCounters();
    applyStimulus(1'b1, 1'b0, 8'h30);
    waitDone("t1_done_wr", 0, 40, cyc);
    checkOutput("t1_done_cycle", cyc, 17);
    idleCycles(1);
    checkOutput("t1_busy_after", busy_o, 0);
    checkOutput("t1_we_count", weCount, 16);
    checkOutput("t1_done_count", doneWrCount, 1);

    // Test 2: read back and transmit
    clearCounters();
    applyStimulus(1'b0, 1'b1, 8'h00);
    waitDone("t2_done_rd", 1, 600, cyc);
    idleCycles(1);
    checkOutput("t2_busy_after", busy_o, 0);
    checkOutput("t2_tx_count", txCount, 16);
    checkOutput("t2_done_count", doneRdCount, 1);
    checkOutput("t2_we_count", weCount, 0);
    for (int i = 0; i < 16; i++) checkOutput("t2_byte", txBytes[i], 8'h30 + i);

    // Test 3: wrapping pattern
    applyStimulus(1'b1, 1'b0, 8'hF8);
    waitDone("t3_done_wr", 0, 40, cyc);
    idleCycles(2);
    clearCounters();
    applyStimulus(1'b0, 1'b1, 8'h00);
    waitDone("t3_done_rd", 1, 600, cyc);
    idleCycles(2);
    checkOutput("t3_byte0", txBytes[0], 8'hF8);
    checkOutput("t3_byte7", txBytes[7], 8'hFF);
    checkOutput("t3_byte8", txBytes[8], 8'h00);
    checkOutput("t3_byte15", txBytes[15], 8'h07);

    // Test 4: simultaneous starts, then ignored starts while busy
    clearCounters();
    applyStimulus(1'b1, 1'b1, 8'h55);
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'hAA);
    applyStimulus(1'b0, 1'b1, 8'h00);
    waitDone("t4_done_wr", 0, 40, cyc);
    idleCycles(30);
    checkOutput("t4_tx_count", txCount, 0);
    checkOutput("t4_done_wr_count", doneWrCount, 1);
    checkOutput("t4_done_rd_count", doneRdCount, 0);
    checkOutput("t4_busy", busy_o, 0);

    // Test 5: reset during the read pass, then restart
    clearCounters();
    applyStimulus(1'b0, 1'b1, 8'h00);
    cyc = 0;
    while (txCount < 5 && cyc < 200) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    checkOutput("t5_reached_5th", (txCount >= 5) ? 1 : 0, 1);
    rst_ni = 1'b0;
    #1;
    checkResetOutputs("t5_reset");
    idleCycles(3);
    rst_ni = 1'b1;
    idleCycles(2);
    checkOutput("t5_no_done", doneRdCount, 0);
    clearCounters();
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("t5_restart_addr", mem_addr_o, 0);
    waitDone("t5_done_rd", 1, 600, cyc);
    idleCycles(2);
    checkOutput("t5_byte0", txBytes[0], 8'h55);
    checkOutput("t5_byte15", txBytes[15], 8'h64);
    checkOutput("t5_tx_count", txCount, 16);

    // Test 6: stray tx_done during the request cycle
    earlyDone = 1'b1;
    clearCounters();
    applyStimulus(1'b0, 1'b1, 8'h00);
    waitDone("t6_done_rd", 1, 600, cyc);
    idleCycles(5);
    earlyDone = 1'b0;
    checkOutput("t6_tx_count", txCount, 16);
    checkOutput("t6_done_count", doneRdCount, 1);
    checkOutput("t6_byte3", txBytes[3], 8'h58);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
